// File: rtl/lfsr_period_monitor_if.sv
// Bus between an LFSR stage (master) and lfsr_period_monitor (slave).
// The visited/full_cover coverage signals exist only with LFSR_PERIOD_COVER_EN.
interface lfsr_period_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] state_in;
    logic             state_vld;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic             stuck;
    logic             ovf;
`ifdef LFSR_PERIOD_COVER_EN
    logic [2**WIDTH-1:0] visited;
    logic                full_cover;
`endif

    modport master (
        output state_in, state_vld, start,
        input  busy, done, period, stuck, ovf
`ifdef LFSR_PERIOD_COVER_EN
        , input visited, full_cover
`endif
    );

    modport slave (
        input  state_in, state_vld, start,
        output busy, done, period, stuck, ovf
`ifdef LFSR_PERIOD_COVER_EN
        , output visited, full_cover
`endif
    );
endinterface

// File: rtl/lfsr_period_monitor.sv
// LFSR period monitor: captures a reference state, counts strobed steps until
// it recurs and reports period, lock-up (period 1) and counter overflow.
// Optional state-coverage bitmap enabled by defining LFSR_PERIOD_COVER_EN.
module lfsr_period_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    lfsr_period_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nxt;
    logic             hit;
    logic             lim;
    logic             busy_q, done_q, stuck_q, ovf_q;
    logic [CNT_W-1:0] period_q;

    assign nxt = cnt_q + CNT_W'(1);
    assign hit = (bus.state_in == ref_q);
    assign lim = (nxt == '1);

    // Next-state decode; start overrides everything, including a same-cycle strobe
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ARM;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ARM:  if (bus.state_vld) state_d = RUN;
                RUN:  if (bus.state_vld && (hit || lim)) state_d = DONE;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ARM) || (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Reference capture, step counting and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            stuck_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.start) begin
            cnt_q    <= '0;
            period_q <= '0;
            stuck_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.state_vld) begin
            if (state_q == ARM) begin
                ref_q <= bus.state_in;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                // Equality is checked before the overflow limit
                if (hit) begin
                    period_q <= nxt;
                    stuck_q  <= (nxt == CNT_W'(1));
                end else if (lim) begin
                    period_q <= '1;
                    ovf_q    <= 1'b1;
                end else begin
                    cnt_q <= nxt;
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.period = period_q;
    assign bus.stuck  = stuck_q;
    assign bus.ovf    = ovf_q;

`ifdef LFSR_PERIOD_COVER_EN
    logic [2**WIDTH-1:0] visited_q, visited_d;
    logic                full_cover_q;

    // Mark every state sampled while measuring; cleared by start
    always_comb begin
        visited_d = visited_q;
        if (bus.start) begin
            visited_d = '0;
        end else if (bus.state_vld && ((state_q == ARM) || (state_q == RUN))) begin
            visited_d[bus.state_in] = 1'b1;
        end
    end

    // Coverage registers; full_cover qualifies the bitmap with the done state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            visited_q    <= '0;
            full_cover_q <= 1'b0;
        end else begin
            visited_q    <= visited_d;
            full_cover_q <= (state_d == DONE) && (&visited_d);
        end
    end

    assign bus.visited    = visited_q;
    assign bus.full_cover = full_cover_q;
`endif
endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Scoreboard bench for lfsr_period_monitor: stimulus pushes expected results,
// per-DUT monitors pop and compare on each rising edge of done.
module tb_lfsr_period_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_period_monitor_if #(.WIDTH(4), .CNT_W(8)) bus  ();
    lfsr_period_monitor_if #(.WIDTH(4), .CNT_W(4)) bus2 ();

    lfsr_period_monitor #(.WIDTH(4), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    lfsr_period_monitor #(.WIDTH(4), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        string      tag;
        logic [7:0] period;
        logic       stuck;
        logic       ovf;
        logic [15:0] visited;
        logic       full_cover;
    } res_t;

    res_t q1[$];
    res_t q2[$];
    res_t act1, act2;
    int   tests = 0;
    int   fails = 0;
    logic d1_prev = 1'b0;
    logic d2_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input res_t a, input res_t e);
        check({e.tag, ".period"}, 32'(a.period), 32'(e.period));
        check({e.tag, ".stuck"},  32'(a.stuck),  32'(e.stuck));
        check({e.tag, ".ovf"},    32'(a.ovf),    32'(e.ovf));
`ifdef LFSR_PERIOD_COVER_EN
        check({e.tag, ".visited"},    32'(a.visited),    32'(e.visited));
        check({e.tag, ".full_cover"}, 32'(a.full_cover), 32'(e.full_cover));
`endif
    endtask

    function automatic res_t mk(input string tag, input logic [7:0] p, input logic s,
                                input logic o, input logic [15:0] v, input logic fc);
        res_t r;
        r.tag = tag; r.period = p; r.stuck = s; r.ovf = o; r.visited = v; r.full_cover = fc;
        return r;
    endfunction

    // Monitor for the CNT_W=8 instance
    always @(negedge clk) begin
        if (bus.done && !d1_prev) begin
            act1.tag = "m1"; act1.period = bus.period; act1.stuck = bus.stuck; act1.ovf = bus.ovf;
`ifdef LFSR_PERIOD_COVER_EN
            act1.visited = bus.visited; act1.full_cover = bus.full_cover;
`else
            act1.visited = '0; act1.full_cover = 1'b0;
`endif
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb1_unexpected: done with period %0d, expected no result", bus.period);
            end else begin
                compare(act1, q1.pop_front());
            end
        end
        d1_prev = bus.done;
    end

    // Monitor for the CNT_W=4 instance
    always @(negedge clk) begin
        if (bus2.done && !d2_prev) begin
            act2.tag = "m2"; act2.period = 8'(bus2.period); act2.stuck = bus2.stuck; act2.ovf = bus2.ovf;
`ifdef LFSR_PERIOD_COVER_EN
            act2.visited = bus2.visited; act2.full_cover = bus2.full_cover;
`else
            act2.visited = '0; act2.full_cover = 1'b0;
`endif
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb2_unexpected: done with period %0d, expected no result", bus2.period);
            end else begin
                compare(act2, q2.pop_front());
            end
        end
        d2_prev = bus2.done;
    end

    function automatic logic [3:0] lfsr_nx(input logic [3:0] s, input bit aug);
        logic fb;
        fb = s[3] ^ s[2];
        if (aug && (s[2:0] == 3'b000)) fb = ~fb;
        return {s[2:0], fb};
    endfunction

    task automatic strobe(input int sel, input logic [3:0] s);
        @(negedge clk);
        if (sel == 1) begin bus.state_in = s; bus.state_vld = 1'b1; end
        else begin bus2.state_in = s; bus2.state_vld = 1'b1; end
        @(negedge clk);
        bus.state_vld = 1'b0; bus2.state_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 1) bus.start = 1'b1; else bus2.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus2.start = 1'b0;
    endtask

    task automatic run_lfsr(input int sel, input logic [3:0] s0, input int n, input bit aug,
                            output logic [3:0] s_out);
        logic [3:0] s;
        s = s0;
        for (int i = 0; i < n; i++) begin
            strobe(sel, s);
            s = lfsr_nx(s, aug);
        end
        s_out = s;
    endtask

    task automatic wait_done(input int sel, input string name);
        int k;
        k = 0;
        while (k < 400 && !((sel == 1) ? bus.done : bus2.done)) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 400) begin
            fails++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles, expected 1", name, k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] s;
        bus.state_in = '0; bus.state_vld = 1'b0; bus.start = 1'b0;
        bus2.state_in = '0; bus2.state_vld = 1'b0; bus2.start = 1'b0;

        #2 rst = 1'b0;
        #20;
        check("rst.busy",   32'(bus.busy),   0);
        check("rst.done",   32'(bus.done),   0);
        check("rst.period", 32'(bus.period), 0);
        check("rst.stuck",  32'(bus.stuck),  0);
        check("rst.ovf",    32'(bus.ovf),    0);
`ifdef LFSR_PERIOD_COVER_EN
        check("rst.visited",    32'(bus.visited),    0);
        check("rst.full_cover", 32'(bus.full_cover), 0);
`endif
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain LFSR from 1000: ref + 15 steps
        q1.push_back(mk("plain", 8'd15, 1'b0, 1'b0, 16'hFFFE, 1'b0));
        pulse_start(1);
        check("plain.busy_armed", 32'(bus.busy), 1);
        run_lfsr(1, 4'b1000, 16, 1'b0, s);
        wait_done(1, "plain");
        check("plain.busy_after", 32'(bus.busy), 0);
        check("plain.done_level", 32'(bus.done), 1);

        // Augmented LFSR from 0000: 16 distinct states
        q1.push_back(mk("aug", 8'd16, 1'b0, 1'b0, 16'hFFFF, 1'b1));
        pulse_start(1);
        check("aug.done_cleared", 32'(bus.done), 0);
        run_lfsr(1, 4'b0000, 17, 1'b1, s);
        wait_done(1, "aug");

        // Lock-up: constant 0000
        q1.push_back(mk("stuck", 8'd1, 1'b1, 1'b0, 16'h0001, 1'b0));
        pulse_start(1);
        strobe(1, 4'b0000);
        strobe(1, 4'b0000);
        wait_done(1, "stuck");
        // Strobes in DONE must not disturb the held result
        strobe(1, 4'b0101);
        check("stuck.hold_period", 32'(bus.period), 1);
        check("stuck.hold_done",   32'(bus.done),   1);

        // Restart mid-RUN after 5 strobes
        q1.push_back(mk("restart", 8'd15, 1'b0, 1'b0, 16'hFFFE, 1'b0));
        pulse_start(1);
        run_lfsr(1, 4'b1000, 5, 1'b0, s);
        pulse_start(1);
        check("restart.busy", 32'(bus.busy), 1);
        check("restart.done", 32'(bus.done), 0);
        run_lfsr(1, s, 16, 1'b0, s);
        wait_done(1, "restart");

        // start coincident with a strobe: that 0000 sample must not become ref
        q1.push_back(mk("coinc", 8'd15, 1'b0, 1'b0, 16'hFFFE, 1'b0));
        @(negedge clk);
        bus.start = 1'b1; bus.state_vld = 1'b1; bus.state_in = 4'b0000;
        @(negedge clk);
        bus.start = 1'b0; bus.state_vld = 1'b0;
        repeat (2) @(negedge clk);
        run_lfsr(1, 4'b1000, 16, 1'b0, s);
        wait_done(1, "coinc");

        // Asynchronous reset while holding a result
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_done.period", 32'(bus.period), 0);
        check("rst_done.done",   32'(bus.done),   0);
        @(negedge clk) rst = 1'b1;

        // Asynchronous reset mid-RUN
        pulse_start(1);
        run_lfsr(1, 4'b1000, 3, 1'b0, s);
        check("rst_run.busy_before", 32'(bus.busy), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_run.busy",   32'(bus.busy),   0);
        check("rst_run.done",   32'(bus.done),   0);
        check("rst_run.period", 32'(bus.period), 0);
        check("rst_run.stuck",  32'(bus.stuck),  0);
        check("rst_run.ovf",    32'(bus.ovf),    0);
        @(negedge clk) rst = 1'b1;
        // Strobes without start stay in IDLE
        for (int i = 0; i < 4; i++) strobe(1, 4'b0000);
        check("idle.done", 32'(bus.done), 0);
        check("idle.busy", 32'(bus.busy), 0);
        q1.push_back(mk("post_rst", 8'd1, 1'b1, 1'b0, 16'h0001, 1'b0));
        pulse_start(1);
        strobe(1, 4'b0000);
        strobe(1, 4'b0000);
        wait_done(1, "post_rst");

        // CNT_W=4 overflow: ref 0 then 1..15, no recurrence
        q2.push_back(mk("ovf", 8'h0F, 1'b0, 1'b1, 16'hFFFF, 1'b1));
        pulse_start(2);
        for (int i = 0; i < 16; i++) strobe(2, 4'(i));
        wait_done(2, "ovf");

        check("sb1.drained", 32'(q1.size()), 0);
        check("sb2.drained", 32'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
